// File: rtl/tpu_pkg.sv
// Shared TPU definitions: instruction format, opcodes and the loader state encoding.
package tpu_pkg;

    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned IMEM_DEPTH = 8;
    localparam int unsigned OPCODE_W   = 3;

    typedef enum logic [OPCODE_W-1:0] {
        OpNopEnd    = 3'b000,
        OpLoadAddr  = 3'b001,
        OpLoadWeight = 3'b010,
        OpLoadInput = 3'b011,
        OpCompute   = 3'b100,
        OpStore     = 3'b101
    } opcode_e;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StArmed,
        StRun
    } loader_state_e;

    // Opcode field of an instruction word (top OPCODE_W bits).
    function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: OPCODE_W];
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Host-to-loader instruction stream: valid/ready handshake with data and last marker.
interface instr_loader_if #(
    parameter int unsigned INSTR_W = 16
);
    logic               host_valid;
    logic               host_ready;
    logic [INSTR_W-1:0] host_data;
    logic               host_last;

    modport master (
        output host_valid,
        output host_data,
        output host_last,
        input  host_ready
    );

    modport slave (
        input  host_valid,
        input  host_data,
        input  host_last,
        output host_ready
    );
endinterface

// File: rtl/instr_mem.sv
// Instruction store: one synchronous write port, one combinational read port.
// A write with clr_i set also zeroes every other entry in the same cycle.
module instr_mem #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 16,
    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic             clr_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int i = 0; i < Depth; i++) begin
                if (waddr_i == AddrW'(i)) begin
                    mem_q[i] <= wdata_i;
                end else if (clr_i) begin
                    mem_q[i] <= '0;
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_loader.sv
// Loads a program from the host into instruction memory, then launches the sequencer
// with a one-cycle start pulse and waits for it to finish before accepting a new program.
module instr_loader #(
    parameter int unsigned IMEM_DEPTH = 8,
    parameter int unsigned INSTR_W    = 16,
    localparam int unsigned AddrW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1,
    localparam int unsigned LenW  = $clog2(IMEM_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    instr_loader_if.slave      host,
    input  logic [AddrW-1:0]   fetch_addr_i,
    output logic [INSTR_W-1:0] fetch_data_o,
    output logic [LenW-1:0]    prog_len_o,
    output logic               start_o,
    input  logic               tpu_done_i,
    output logic               err_o
);
    import tpu_pkg::*;

    localparam logic [AddrW-1:0] LastIdx = AddrW'(IMEM_DEPTH - 1);

    loader_state_e      state_q, state_d;
    logic [LenW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LenW-1:0]    prog_len_q, prog_len_d;
    logic               err_q, err_d;
    logic               start_q, start_d;

    logic               xfer;
    logic [AddrW-1:0]   wr_idx;
    logic               is_end;
    logic               at_last;
    logic               term;
    logic               overflow;
    logic               mem_we;
    logic               mem_clr;
    logic [INSTR_W-1:0] mem_rdata;

    assign host.host_ready = (state_q == StIdle) || (state_q == StLoad);
    assign xfer            = host.host_valid && host.host_ready;

    // The first word of a program always lands in entry 0, whatever wr_ptr holds.
    assign wr_idx   = (state_q == StIdle) ? '0 : wr_ptr_q[AddrW-1:0];
    assign is_end   = get_opcode(host.host_data) == OpNopEnd;
    assign at_last  = wr_idx == LastIdx;
    assign term     = is_end || host.host_last || at_last;
    assign overflow = at_last && !is_end && !host.host_last;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        err_d      = err_q;
        start_d    = 1'b0;
        mem_we     = 1'b0;
        mem_clr    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    mem_we     = 1'b1;
                    mem_clr    = 1'b1;
                    wr_ptr_d   = LenW'(1);
                    prog_len_d = LenW'(1);
                    err_d      = overflow;
                    start_d    = term;
                    state_d    = term ? StArmed : StLoad;
                end
            end
            StLoad: begin
                if (xfer) begin
                    mem_we     = 1'b1;
                    wr_ptr_d   = wr_ptr_q + LenW'(1);
                    prog_len_d = prog_len_q + LenW'(1);
                    err_d      = err_q || overflow;
                    start_d    = term;
                    state_d    = term ? StArmed : StLoad;
                end
            end
            StArmed: begin
                state_d = StRun;
            end
            StRun: begin
                if (tpu_done_i) begin
                    wr_ptr_d = '0;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            prog_len_q <= '0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            prog_len_q <= prog_len_d;
            err_q      <= err_d;
            start_q    <= start_d;
        end
    end

    instr_mem #(
        .Depth (IMEM_DEPTH),
        .Width (INSTR_W)
    ) u_instr_mem (
        .clk     (clk),
        .reset   (reset),
        .we_i    (mem_we),
        .clr_i   (mem_clr),
        .waddr_i (wr_idx),
        .wdata_i (host.host_data),
        .raddr_i (fetch_addr_i),
        .rdata_o (mem_rdata)
    );

    // Entries beyond the program read as NOP/END.
    assign fetch_data_o = (LenW'(fetch_addr_i) < prog_len_q) ? mem_rdata : '0;
    assign prog_len_o   = prog_len_q;
    assign start_o      = start_q;
    assign err_o        = err_q;

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 The block SHALL have parameter IMEM_DEPTH, default 8, meaning the number of instruction words held.
REQ-002 The block SHALL have parameter INSTR_W, default 16, meaning the instruction word width: opcode in [15:13], operand in [12:0].
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 host_valid  input  1  host offers an instruction word.
REQ-006 host_ready  output  1  loader can accept a word.
REQ-007 host_data  input  INSTR_W  instruction word from the host.
REQ-008 host_last  input  1  the offered word is the final word of the program.
REQ-009 fetch_addr  input  3  sequencer read address (instruction pointer).
REQ-010 fetch_data  output  INSTR_W  instruction word at fetch_addr.
REQ-011 prog_len  output  4  number of words stored for the current program, 0..8.
REQ-012 start  output  1  one-cycle pulse that launches the sequencer.
REQ-013 tpu_done  input  1  sequencer has reached FINISH.
REQ-014 err  output  1  sticky flag: program filled memory without an END word.

Function
REQ-015 A transfer SHALL occur only on a rising edge where host_valid && host_ready; host_data is ignored at all other times.
REQ-016 The FSM SHALL have four states: IDLE, LOAD, ARMED and RUN.
REQ-017 host_ready SHALL be 1 in IDLE and LOAD, and 0 in ARMED and RUN, decoded combinationally from state.
REQ-018 IDLE: the first transfer SHALL write mem[0], clear all other entries to 0, set wr_ptr=1, set prog_len=1 and clear err.
REQ-019 IDLE: after the first transfer, the next state SHALL be LOAD unless a termination condition (REQ-021) holds on that same word.
REQ-020 LOAD: each transfer SHALL write mem[wr_ptr], then increment wr_ptr and prog_len by 1.
REQ-021 A load SHALL terminate and go to ARMED when the transferred word has opcode 000 (END), or host_last=1, or it was written to entry IMEM_DEPTH-1.
REQ-022 err SHALL be set if the word written to entry IMEM_DEPTH-1 has a nonzero opcode and host_last=0.
REQ-023 END and host_last on the same word SHALL terminate once, with no error.
REQ-024 ARMED SHALL last exactly one cycle, with start=1 (registered), then go to RUN.
REQ-025 RUN: the FSM SHALL wait for tpu_done=1, then return to IDLE and set wr_ptr=0.
REQ-026 On return to IDLE, memory contents, prog_len and err SHALL be retained until the next first transfer.
REQ-027 tpu_done SHALL be ignored in IDLE, LOAD and ARMED.
REQ-028 fetch_data SHALL be combinational: mem[fetch_addr] when fetch_addr < prog_len, else 16'h0000 (NOP/END).
REQ-029 fetch_data SHALL be valid in every state, and a write SHALL become visible on fetch_data the cycle after the transfer.
REQ-030 Latency from the terminating transfer to the start pulse SHALL be exactly 1 cycle.

Reset
REQ-031 Reset SHALL force state=IDLE, wr_ptr=0, prog_len=0, err=0, start=0 and all memory entries to 0, independently of clk.
REQ-032 Reset asserted mid-LOAD or mid-RUN SHALL discard the partial program; the first transfer after release is stored as word 0.
REQ-033 After reset: host_ready=1, fetch_data=0.

Structure
REQ-034 Shared package tpu_pkg SHALL hold the opcode enum (NOP_END=000, LOAD_ADDR=001, LOAD_WEIGHT=010, LOAD_INPUT=011, COMPUTE=100, STORE=101), INSTR_W, IMEM_DEPTH and the loader state enum.
REQ-035 The storage array SHALL be a sub-module instr_mem: IMEM_DEPTH x INSTR_W, one synchronous write port, one combinational read port, asynchronous clear.

Verification
REQ-036 Load 0x200F, 0x4000, 0x201E, 0x6000, 0x8000, 0x2007, 0xA000, 0x0000, one per cycle -> END word fills entry 7; start pulses 1 cycle after the last transfer; prog_len=8; err=0; fetch 0..7 returns the words in order.
REQ-037 Load 0x200F, 0x4000 with host_last on the second word -> ARMED, then start; prog_len=2; fetch_addr=5 returns 0x0000.
REQ-038 Load 8 words of 0x8000 with host_last=0 -> err=1 after the 8th transfer; start pulses; host_ready=0.
REQ-039 In RUN, hold host_valid=1 with 0xFFFF -> no write; assert tpu_done -> IDLE; next word 0x2001 is written to entry 0 and clears err.
REQ-040 Assert reset after 3 words of a load -> prog_len=0, all fetches return 0, no start pulse; reload 0x0000 -> start pulses with prog_len=1.
REQ-041 host_valid toggling 1,0,1 with bubbles -> only cycles with valid&&ready write, and entries are contiguous with no gaps.
